// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC capture controller: FSM state encoding and
// the default FIFO depth used to clamp the requested sample count.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int FIFO_DEPTH = 4096;

endpackage

// File: rtl/cycle_timer.sv
// 32-bit down-counting interval timer. Load with (cycles - 1); o_expire is
// asserted in the last enabled cycle of the interval.
module cycle_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic        o_expire
);

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: clears the FIFO, gates ADC writes until the requested
// count (or full/timeout), then drains the FIFO to the sink one word per 2 cycles.
module adc_capture_ctrl #(
    parameter int          CLR_CYCLES     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16_777_216,
    parameter int          FIFO_DEPTH     = adc_ctrl_pkg::FIFO_DEPTH
) (
    input  logic        clk_256M,
    input  logic        rst_n,
    input  logic        start_p,
    input  logic        abort_p,
    input  logic [15:0] sample_num,
    input  logic [12:0] fifo_wr_num,
    input  logic [12:0] fifo_rd_num,
    input  logic        fifo_wrfull,
    input  logic        sink_rdy,
    output logic        fifo_aclr,
    output logic        fifo_wr_control,
    output logic        fifo_rd_control,
    output logic        data_valid,
    output logic        busy,
    output logic        done_p,
    output logic        timeout_p
);
    import adc_ctrl_pkg::*;

    state_t      r_state;
    logic [12:0] r_n;
    logic [12:0] r_rd_cnt;
    logic        r_abort;
    logic        r_early;
    logic        r_aclr, r_wr_ctrl, r_rd_ctrl, r_dvalid, r_done_p, r_timeout_p;

    logic        w_load;
    logic [31:0] w_load_val;
    logic        w_tmr_en;
    logic        w_expire;
    logic        w_abort;
    logic        w_cap_hit;
    logic        w_strobe;

    assign w_abort   = abort_p && (r_state != ST_IDLE);
    assign w_tmr_en  = (r_state == ST_CLEAR) || (r_state == ST_CAPTURE);
    assign w_cap_hit = (fifo_wr_num >= r_n) || fifo_wrfull;
    assign w_strobe  = sink_rdy && (fifo_rd_num != '0) && (r_rd_cnt < r_n) && !r_rd_ctrl;

    // The one timer is reloaded on every entry into CLEAR or CAPTURE.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_abort || (r_state == ST_IDLE && start_p && !abort_p && sample_num != '0)) begin
            w_load     = 1'b1;
            w_load_val = 32'(CLR_CYCLES - 1);
        end else if (r_state == ST_CLEAR && w_expire && !r_abort) begin
            w_load     = 1'b1;
            w_load_val = TIMEOUT_CYCLES - 32'd1;
        end
    end

    cycle_timer u_timer (
        .i_clk      (clk_256M),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_rd_cnt    <= '0;
            r_abort     <= 1'b0;
            r_early     <= 1'b0;
            r_aclr      <= 1'b0;
            r_wr_ctrl   <= 1'b0;
            r_rd_ctrl   <= 1'b0;
            r_dvalid    <= 1'b0;
            r_done_p    <= 1'b0;
            r_timeout_p <= 1'b0;
        end else begin
            r_done_p    <= 1'b0;
            r_timeout_p <= 1'b0;
            r_rd_ctrl   <= 1'b0;
            r_dvalid    <= r_rd_ctrl;
            if (w_abort) begin
                r_state   <= ST_CLEAR;
                r_abort   <= 1'b1;
                r_aclr    <= 1'b1;
                r_wr_ctrl <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_p && !abort_p) begin
                            r_rd_cnt <= '0;
                            r_early  <= 1'b0;
                            r_abort  <= 1'b0;
                            if (sample_num == '0) begin
                                r_n      <= '0;
                                r_state  <= ST_DONE;
                                r_done_p <= 1'b1;
                            end else begin
                                r_n     <= (32'(sample_num) > 32'(FIFO_DEPTH)) ?
                                           13'(FIFO_DEPTH) : sample_num[12:0];
                                r_state <= ST_CLEAR;
                                r_aclr  <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        if (w_expire) begin
                            r_aclr <= 1'b0;
                            if (r_abort) begin
                                r_state <= ST_IDLE;
                                r_abort <= 1'b0;
                            end else begin
                                r_state   <= ST_CAPTURE;
                                r_wr_ctrl <= 1'b1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (w_cap_hit) begin
                            r_state   <= ST_DRAIN;
                            r_wr_ctrl <= 1'b0;
                            r_early   <= fifo_wrfull;
                        end else if (w_expire) begin
                            r_state     <= ST_DRAIN;
                            r_wr_ctrl   <= 1'b0;
                            r_early     <= 1'b1;
                            r_timeout_p <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        // Early exits stop once the FIFO is empty and no read is in flight.
                        if ((r_rd_cnt == r_n) || (r_early && fifo_rd_num == '0 && !r_rd_ctrl)) begin
                            r_state  <= ST_DONE;
                            r_done_p <= 1'b1;
                        end else if (w_strobe) begin
                            r_rd_ctrl <= 1'b1;
                            r_rd_cnt  <= r_rd_cnt + 13'd1;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign fifo_aclr       = r_aclr;
    assign fifo_wr_control = r_wr_ctrl;
    assign fifo_rd_control = r_rd_ctrl;
    assign data_valid      = r_dvalid;
    assign busy            = (r_state != ST_IDLE);
    assign done_p          = r_done_p;
    assign timeout_p       = r_timeout_p;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a FIFO fill-level model and a
// per-capture scoreboard of expected event counts.
module tb_adc_capture_ctrl;

    logic        clk_256M = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, abort_p = 1'b0;
    logic [15:0] sample_num = '0;
    logic [12:0] m_cnt = '0;
    logic        fifo_wrfull, sink_rdy;
    logic        sink_tog = 1'b0, r_tog = 1'b0;
    logic        sel = 1'b0;
    int          wr_cap = 4096;

    logic a_aclr, a_wr, a_rd, a_dv, a_busy, a_done, a_to;
    logic b_aclr, b_wr, b_rd, b_dv, b_busy, b_done, b_to;
    logic m_aclr, m_wr, m_rd, m_dv, m_busy, m_done, m_to;

    always #5 clk_256M = ~clk_256M;

    assign fifo_wrfull = (m_cnt >= 13'd4096);
    assign sink_rdy    = sink_tog ? r_tog : 1'b1;
    assign m_aclr = sel ? b_aclr : a_aclr;
    assign m_wr   = sel ? b_wr   : a_wr;
    assign m_rd   = sel ? b_rd   : a_rd;
    assign m_dv   = sel ? b_dv   : a_dv;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_to   = sel ? b_to   : a_to;

    adc_capture_ctrl u_dut (
        .clk_256M(clk_256M), .rst_n(rst_n), .start_p(start_a), .abort_p(abort_p),
        .sample_num(sample_num), .fifo_wr_num(m_cnt), .fifo_rd_num(m_cnt),
        .fifo_wrfull(fifo_wrfull), .sink_rdy(sink_rdy),
        .fifo_aclr(a_aclr), .fifo_wr_control(a_wr), .fifo_rd_control(a_rd),
        .data_valid(a_dv), .busy(a_busy), .done_p(a_done), .timeout_p(a_to)
    );

    adc_capture_ctrl #(.TIMEOUT_CYCLES(32'd50)) u_dut_to (
        .clk_256M(clk_256M), .rst_n(rst_n), .start_p(start_b), .abort_p(abort_p),
        .sample_num(sample_num), .fifo_wr_num(m_cnt), .fifo_rd_num(m_cnt),
        .fifo_wrfull(fifo_wrfull), .sink_rdy(sink_rdy),
        .fifo_aclr(b_aclr), .fifo_wr_control(b_wr), .fifo_rd_control(b_rd),
        .data_valid(b_dv), .busy(b_busy), .done_p(b_done), .timeout_p(b_to)
    );

    // FIFO level model: one word per write-enable cycle up to wr_cap, one per read strobe
    always @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n)                                m_cnt <= '0;
        else if (m_aclr)                           m_cnt <= '0;
        else if (m_wr && int'(m_cnt) < wr_cap)     m_cnt <= m_cnt + 13'd1;
        else if (m_rd && m_cnt != '0)              m_cnt <= m_cnt - 13'd1;
        if (sink_tog) r_tog <= ~r_tog;
    end

    int cyc_no = 0, cnt_aclr, cnt_wr, cnt_rd, cnt_dv, cnt_done, cnt_to;
    int dv_err, sp_err, first_wr, to_cyc;
    logic prev_rd = 1'b0;

    always @(negedge clk_256M) begin
        cyc_no++;
        if (m_aclr) cnt_aclr++;
        if (m_wr)   cnt_wr++;
        if (m_rd)   cnt_rd++;
        if (m_dv)   cnt_dv++;
        if (m_done) cnt_done++;
        if (m_to)   cnt_to++;
        if (m_dv !== prev_rd) dv_err++;
        if (m_rd && prev_rd)  sp_err++;
        if (m_wr && first_wr < 0) first_wr = cyc_no;
        if (m_to) to_cyc = cyc_no;
        prev_rd = m_rd;
    end

    typedef struct {
        string tag;
        int aclr, wr, rd, dv, done, to, lat;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_256M); #1; end
    endtask

    task automatic clr_mon();
        cnt_aclr = 0; cnt_wr = 0; cnt_rd = 0; cnt_dv = 0; cnt_done = 0; cnt_to = 0;
        dv_err = 0; sp_err = 0; first_wr = -1; to_cyc = -1;
    endtask

    // Drive one capture, wait (bounded) for done_p, then compare against the popped expectation
    task automatic run_cap(input string tag, input logic inst, input logic [15:0] s, input int cap,
                           input int e_aclr, input int e_wr, input int e_rd, input int e_to,
                           input int e_lat);
        exp_t e, got;
        int lat;
        sel = inst; wr_cap = cap; sample_num = s;
        clr_mon();
        e.tag = tag; e.aclr = e_aclr; e.wr = e_wr; e.rd = e_rd; e.dv = e_rd;
        e.done = 1; e.to = e_to; e.lat = e_lat;
        sb.push_back(e);
        if (inst) start_b = 1'b1; else start_a = 1'b1;
        cyc(1);
        start_a = 1'b0; start_b = 1'b0;
        lat = 0;
        while (m_done !== 1'b1 && lat < 20000) begin cyc(1); lat++; end
        cyc(3);
        got = sb.pop_front();
        chk({got.tag, " done_p count"}, cnt_done, got.done);
        chk({got.tag, " aclr cycles"}, cnt_aclr, got.aclr);
        chk({got.tag, " wr_control cycles"}, cnt_wr, got.wr);
        chk({got.tag, " rd strobes"}, cnt_rd, got.rd);
        chk({got.tag, " data_valid count"}, cnt_dv, got.dv);
        chk({got.tag, " timeout_p count"}, cnt_to, got.to);
        chk({got.tag, " dv lag errors"}, dv_err, 0);
        chk({got.tag, " strobe spacing errors"}, sp_err, 0);
        chk({got.tag, " busy after done"}, int'(m_busy), 0);
        if (got.lat >= 0) chk({got.tag, " done latency"}, lat, got.lat);
    endtask

    int a0, w0, r0, wait_n;

    initial begin
        clr_mon();
        cyc(2);
        chk("reset outputs", int'({a_aclr, a_wr, a_rd, a_dv, a_busy, a_done, a_to}), 0);
        rst_n = 1'b1;
        cyc(5);
        chk("post-reset no aclr", cnt_aclr, 0);
        chk("post-reset idle", int'(a_busy), 0);

        run_cap("n100", 1'b0, 16'd100, 4096, 8, 101, 100, 0, -1);
        run_cap("n5000", 1'b0, 16'd5000, 4096, 8, 4097, 4096, 0, -1);
        run_cap("n0", 1'b0, 16'd0, 4096, 0, 0, 0, 0, 0);
        run_cap("tmo", 1'b1, 16'd20, 10, 8, 50, 10, 1, -1);
        chk("tmo timeout cycle", to_cyc - first_wr, 50);
        sel = 1'b0; wr_cap = 4096;

        // start and abort together in IDLE: abort wins
        clr_mon();
        sample_num = 16'd100;
        start_a = 1'b1; abort_p = 1'b1;
        cyc(1);
        start_a = 1'b0; abort_p = 1'b0;
        chk("start+abort busy", int'(a_busy), 0);
        cyc(12);
        chk("start+abort aclr", cnt_aclr, 0);
        chk("start+abort wr", cnt_wr, 0);

        // abort mid-DRAIN with a toggling sink
        clr_mon();
        sink_tog = 1'b1;
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        wait_n = 0;
        while (cnt_rd < 10 && wait_n < 3000) begin cyc(1); wait_n++; end
        chk("abort reached drain", int'(cnt_rd >= 10), 1);
        a0 = cnt_aclr; w0 = cnt_wr;
        abort_p = 1'b1;
        cyc(1);
        abort_p = 1'b0;
        r0 = cnt_rd;
        chk("abort aclr asserted", int'(a_aclr), 1);
        cyc(2);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(12);
        chk("abort aclr cycles", cnt_aclr - a0, 8);
        chk("abort idle", int'(a_busy), 0);
        chk("abort no done", cnt_done, 0);
        chk("abort no reads", cnt_rd - r0, 0);
        chk("abort no writes", cnt_wr - w0, 0);
        cyc(10);
        chk("start in clear ignored", int'(a_busy), 0);
        sink_tog = 1'b0;

        // reset mid-CAPTURE
        clr_mon();
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        wait_n = 0;
        while (cnt_wr < 20 && wait_n < 200) begin cyc(1); wait_n++; end
        chk("rst reached capture", int'(a_wr), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async outputs", int'({a_aclr, a_wr, a_rd, a_dv, a_busy, a_done, a_to}), 0);
        cyc(2);
        rst_n = 1'b1;
        clr_mon();
        cyc(6);
        chk("rst release idle", int'(a_busy), 0);
        chk("rst release no aclr", cnt_aclr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 The block SHALL have parameter CLR_CYCLES, default 8: number of cycles fifo_aclr is held high.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd16_777_216: maximum number of cycles spent in CAPTURE.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4096: sample_num clamp limit.
REQ-004 The block SHALL have port clk_256M, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port start_p, input, 1 bit: one-cycle capture command (driven from rxd_flag_p).
REQ-007 The block SHALL have port abort_p, input, 1 bit: one-cycle abort command.
REQ-008 The block SHALL have port sample_num, input, 16 bits: requested sample count, latched at start.
REQ-009 The block SHALL have port fifo_wr_num, input, 13 bits: FIFO write-side fill level, synchronous to clk_256M.
REQ-010 The block SHALL have port fifo_rd_num, input, 13 bits: FIFO read-side fill level, synchronous to clk_256M.
REQ-011 The block SHALL have port fifo_wrfull, input, 1 bit: FIFO full flag.
REQ-012 The block SHALL have port sink_rdy, input, 1 bit: downstream (UART/host) can accept a word.
REQ-013 The block SHALL have port fifo_aclr, output, 1 bit: FIFO clear.
REQ-014 The block SHALL have port fifo_wr_control, output, 1 bit: write enable to the ADC front end.
REQ-015 The block SHALL have port fifo_rd_control, output, 1 bit: one-cycle read strobe.
REQ-016 The block SHALL have port data_valid, output, 1 bit: FIFO output word valid, fifo_rd_control delayed by 1 cycle.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-018 The block SHALL have port done_p, output, 1 bit: one-cycle pulse on completion.
REQ-019 The block SHALL have port timeout_p, output, 1 bit: one-cycle pulse on capture timeout.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, CAPTURE, DRAIN and DONE, one-hot or binary.
REQ-021 In IDLE, start_p SHALL latch n = min(sample_num, FIFO_DEPTH) and go to CLEAR; if sample_num = 0, it SHALL instead go directly to DONE.
REQ-022 In CLEAR, fifo_aclr SHALL be high for exactly CLR_CYCLES cycles, then the FSM SHALL enter CAPTURE.
REQ-023 In CAPTURE, fifo_wr_control SHALL be high; the FSM SHALL exit to DRAIN when fifo_wr_num >= n or fifo_wrfull = 1, registered, with fifo_wr_control low the next cycle.
REQ-024 The CAPTURE cycle counter SHALL be 32 bits and reach TIMEOUT_CYCLES; on timeout it SHALL pulse timeout_p, drop fifo_wr_control, and go to DRAIN (draining the words already held).
REQ-025 In DRAIN, fifo_rd_control SHALL pulse when sink_rdy = 1, fifo_rd_num != 0, rd_cnt < n, and no strobe occurred in the previous cycle (at most one strobe every 2 cycles).
REQ-026 Each strobe SHALL increment rd_cnt (13 bits); data_valid SHALL be high exactly 1 cycle after each strobe.
REQ-027 DRAIN SHALL exit to DONE when rd_cnt = n, or when fifo_rd_num = 0 after a timeout or wrfull exit.
REQ-028 DONE SHALL pulse done_p for 1 cycle and return to IDLE.
REQ-029 start_p SHALL be ignored when not in IDLE.
REQ-030 abort_p in any non-IDLE state SHALL force the FSM to CLEAR with no done_p and then to IDLE instead of CAPTURE; abort_p SHALL have priority over every other transition.
REQ-031 When start_p and abort_p are both high in IDLE, abort_p SHALL win and no capture SHALL occur.

Reset
REQ-032 On rst_n = 0, the FSM SHALL enter IDLE; every output, n, rd_cnt and the timer SHALL be 0, asynchronously, including mid-capture.
REQ-033 Reset release SHALL be followed by no fifo_aclr; the first start_p performs the clear.

Structure
REQ-034 A shared package adc_ctrl_pkg SHALL hold the state enumeration and FIFO_DEPTH.
REQ-035 One sub-module, cycle_timer (load/enable/expire, 32 bits), SHALL serve both CLEAR and CAPTURE timing.

Verification
REQ-036 The bench SHALL cover: sample_num = 100, fifo_wr_num ramps, sink_rdy = 1 -> aclr for 8 cycles, 100 strobes, 100 data_valid, one done_p.
REQ-037 The bench SHALL cover: sample_num = 5000 -> n clamped to 4096, exit on wr_num = 4096, 4096 reads.
REQ-038 The bench SHALL cover: sample_num = 0 -> done_p 1 cycle after start, no aclr, no wr_control.
REQ-039 The bench SHALL cover: TIMEOUT_CYCLES = 50, wr_num stuck at 10 -> timeout_p at cycle 50, 10 reads, done_p.
REQ-040 The bench SHALL cover: abort_p mid-DRAIN with sink_rdy toggling -> aclr for 8 cycles, IDLE, no done_p; a start_p in the same run is ignored.
REQ-041 The bench SHALL cover: rst_n low mid-CAPTURE -> all outputs 0 immediately, IDLE after release.
